// File: rtl/divider_host_ctrl.sv
// Host-side sequencer for divider_timing: operand FIFO, one-at-a-time divider handshake, tagged result port.
// Optional WAIT_DONE watchdog and sticky Err_Timeout output are enabled by defining DIVHOST_TIMEOUT_EN.
module divider_host_ctrl #(
  parameter int FIFO_DEPTH  = 4,
  parameter int DIV_TIMEOUT = 32
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Op_Valid,
  input  logic [3:0] Op_X,
  input  logic [3:0] Op_Y,
  output logic       Op_Ready,
  output logic [3:0] Div_Xin,
  output logic [3:0] Div_Yin,
  output logic       Div_Start,
  output logic       Div_Ack,
  input  logic       Div_Done,
  input  logic [3:0] Div_Quotient,
  input  logic [3:0] Div_Remainder,
  output logic       Res_Valid,
  input  logic       Res_Ready,
  output logic [3:0] Res_X,
  output logic [3:0] Res_Y,
  output logic [3:0] Res_Quotient,
  output logic [3:0] Res_Remainder,
  output logic       Res_DivZero,
`ifdef DIVHOST_TIMEOUT_EN
  output logic       Err_Timeout,
`endif
  output logic       Busy
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_DONE,
    S_ACK,
    S_OUT
  } state_t;

  state_t           state_q;
  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push, pop;
  logic [3:0]       head_x, head_y;

  logic [3:0] div_xin_q, div_yin_q;
  logic       div_start_q, div_ack_q;
  logic       res_valid_q, res_dz_q;
  logic [3:0] res_x_q, res_y_q, res_quot_q, res_rem_q;

`ifdef DIVHOST_TIMEOUT_EN
  localparam logic [5:0] TMO_LAST = 6'(DIV_TIMEOUT - 1);
  logic [5:0] tmo_cnt_q;
  logic       err_timeout_q;
  assign Err_Timeout = err_timeout_q;
`endif

  // The head is only popped from a registered count, so a freshly written entry is never bypassed.
  assign Op_Ready = (count_q != DEPTH_C);
  assign push     = Op_Valid && Op_Ready;
  assign pop      = (state_q == S_IDLE) && (count_q != '0);
  assign {head_x, head_y} = fifo_mem[rd_ptr_q];

  // NOTE: storage is deliberately not reset; the pointers and count alone decide which entries are valid.
  always_ff @(posedge Clk) begin
    if (push) fifo_mem[wr_ptr_q] <= {Op_X, Op_Y};
  end

  // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= S_IDLE;
      div_xin_q   <= '0;
      div_yin_q   <= '0;
      div_start_q <= 1'b0;
      div_ack_q   <= 1'b0;
      res_valid_q <= 1'b0;
      res_x_q     <= '0;
      res_y_q     <= '0;
      res_quot_q  <= '0;
      res_rem_q   <= '0;
      res_dz_q    <= 1'b0;
`ifdef DIVHOST_TIMEOUT_EN
      tmo_cnt_q     <= '0;
      err_timeout_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            div_xin_q <= head_x;
            div_yin_q <= head_y;
            res_x_q   <= head_x;
            res_y_q   <= head_y;
            if (head_y == 4'd0) begin
              // Divide-by-zero is answered locally and never touches the divider.
              res_quot_q  <= 4'hF;
              res_rem_q   <= head_x;
              res_dz_q    <= 1'b1;
              res_valid_q <= 1'b1;
              state_q     <= S_OUT;
            end else begin
              res_dz_q    <= 1'b0;
              div_start_q <= 1'b1;
              state_q     <= S_START;
            end
          end
        end
        S_START: begin
          div_start_q <= 1'b0;
          state_q     <= S_WAIT_DONE;
`ifdef DIVHOST_TIMEOUT_EN
          tmo_cnt_q   <= '0;
`endif
        end
        S_WAIT_DONE: begin
          if (Div_Done) begin
            res_quot_q <= Div_Quotient;
            res_rem_q  <= Div_Remainder;
            div_ack_q  <= 1'b1;
            state_q    <= S_ACK;
          end
`ifdef DIVHOST_TIMEOUT_EN
          else if (tmo_cnt_q == TMO_LAST) begin
            // Abort: the Ack pulse returns the divider's handshake to its idle state.
            res_quot_q    <= '0;
            res_rem_q     <= '0;
            err_timeout_q <= 1'b1;
            div_ack_q     <= 1'b1;
            state_q       <= S_ACK;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 6'd1;
          end
`endif
        end
        S_ACK: begin
          div_ack_q   <= 1'b0;
          res_valid_q <= 1'b1;
          state_q     <= S_OUT;
        end
        S_OUT: begin
          if (Res_Ready) begin
            res_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign Div_Xin       = div_xin_q;
  assign Div_Yin       = div_yin_q;
  assign Div_Start     = div_start_q;
  assign Div_Ack       = div_ack_q;
  assign Res_Valid     = res_valid_q;
  assign Res_X         = res_x_q;
  assign Res_Y         = res_y_q;
  assign Res_Quotient  = res_quot_q;
  assign Res_Remainder = res_rem_q;
  assign Res_DivZero   = res_dz_q;
  assign Busy          = (state_q != S_IDLE) || (count_q != '0);

endmodule

// File: tb/tb_divider_host_ctrl.sv
// Directed bench for divider_host_ctrl with a cycle-level divider stub; the timeout scenario needs DIVHOST_TIMEOUT_EN.
module tb_divider_host_ctrl;

  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
    logic [3:0] q;
    logic [3:0] r;
    logic       dz;
  } res_t;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Op_Valid = 1'b0;
  logic [3:0] Op_X = '0, Op_Y = '0;
  logic       Op_Ready;
  logic [3:0] Div_Xin, Div_Yin;
  logic       Div_Start, Div_Ack;
  logic       Div_Done;
  logic [3:0] Div_Quotient, Div_Remainder;
  logic       Res_Valid;
  logic       Res_Ready = 1'b0;
  logic [3:0] Res_X, Res_Y, Res_Quotient, Res_Remainder;
  logic       Res_DivZero;
  logic       Busy;
`ifdef DIVHOST_TIMEOUT_EN
  logic       Err_Timeout;
`endif

  int total = 0;
  int bad = 0;

  divider_host_ctrl dut (
    .Clk(Clk), .Reset(Reset),
    .Op_Valid(Op_Valid), .Op_X(Op_X), .Op_Y(Op_Y), .Op_Ready(Op_Ready),
    .Div_Xin(Div_Xin), .Div_Yin(Div_Yin), .Div_Start(Div_Start), .Div_Ack(Div_Ack),
    .Div_Done(Div_Done), .Div_Quotient(Div_Quotient), .Div_Remainder(Div_Remainder),
    .Res_Valid(Res_Valid), .Res_Ready(Res_Ready), .Res_X(Res_X), .Res_Y(Res_Y),
    .Res_Quotient(Res_Quotient), .Res_Remainder(Res_Remainder), .Res_DivZero(Res_DivZero),
`ifdef DIVHOST_TIMEOUT_EN
    .Err_Timeout(Err_Timeout),
`endif
    .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  // Divider stub: Done is seen by the DUT div_delay clocks after the edge that samples Start.
  int         div_delay = 3;
  logic       stub_hang = 1'b0;
  logic       stub_busy;
  int         stub_cnt;
  logic [3:0] stub_x, stub_y;

  always @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      stub_busy <= 1'b0; stub_cnt <= 0; Div_Done <= 1'b0;
      Div_Quotient <= '0; Div_Remainder <= '0; stub_x <= '0; stub_y <= '0;
    end else if (Div_Ack) begin
      stub_busy <= 1'b0; Div_Done <= 1'b0;
    end else if (!stub_busy) begin
      if (Div_Start) begin
        stub_busy <= 1'b1; stub_cnt <= 1; stub_x <= Div_Xin; stub_y <= Div_Yin;
      end
    end else if (!Div_Done && !stub_hang && stub_cnt == div_delay - 1) begin
      Div_Done <= 1'b1;
      Div_Quotient <= (stub_y != 0) ? stub_x / stub_y : 4'h0;
      Div_Remainder <= (stub_y != 0) ? stub_x % stub_y : 4'h0;
    end else begin
      stub_cnt <= stub_cnt + 1;
    end
  end

  int   n_start = 0, n_ack = 0, n_overlap = 0;
  res_t got_q[$];

  always @(negedge Clk) begin
    if (Div_Start === 1'b1) begin
      n_start++;
      if (stub_busy) n_overlap++;
    end
    if (Div_Ack === 1'b1) n_ack++;
    if (Res_Valid === 1'b1 && Res_Ready === 1'b1)
      got_q.push_back({Res_X, Res_Y, Res_Quotient, Res_Remainder, Res_DivZero});
  end

  // Called at 1ns after a rising edge; returns 1ns after the push edge.
  task automatic push(input logic [3:0] x, input logic [3:0] y, output bit accepted);
    Op_Valid = 1'b1; Op_X = x; Op_Y = y;
    accepted = Op_Ready;
    @(posedge Clk); #1;
    Op_Valid = 1'b0;
  endtask

  task automatic wait_results(input int n, input int budget, output bit ok);
    int k = 0;
    while (got_q.size() < n && k < budget) begin
      @(posedge Clk); #1;
      k++;
    end
    ok = (got_q.size() >= n);
  endtask

  task automatic align();
    @(posedge Clk); #1;
  endtask

  task automatic test_reset();
    #1 Reset = 1'b0;
    #2;
    total++; if (Op_Ready !== 1'b1)  begin bad++; $display("FAIL reset_op_ready got=%b exp=1", Op_Ready); end
    total++; if (Res_Valid !== 1'b0) begin bad++; $display("FAIL reset_res_valid got=%b exp=0", Res_Valid); end
    total++; if ({Div_Start, Div_Ack, Busy, Res_DivZero} !== 4'b0000)
      begin bad++; $display("FAIL reset_ctrl got=%b exp=0000", {Div_Start, Div_Ack, Busy, Res_DivZero}); end
    total++; if ({Div_Xin, Div_Yin, Res_X, Res_Y, Res_Quotient, Res_Remainder} !== 24'h0)
      begin bad++; $display("FAIL reset_data got=%h exp=0", {Div_Xin, Div_Yin, Res_X, Res_Y, Res_Quotient, Res_Remainder}); end
    @(posedge Clk); #1 Reset = 1'b1;
    align();
  endtask

  task automatic test_basic();
    int s0 = n_start, a0 = n_ack, base = got_q.size(), lat = 0;
    bit acc, ok, found = 0;
    res_t e = {4'd15, 4'd2, 4'd7, 4'd1, 1'b0};
    Res_Ready = 1'b1;
    push(4'd15, 4'd2, acc);
    for (int j = 0; j < 50 && !found; j++) begin
      @(negedge Clk);
      if (Res_Valid === 1'b1) begin found = 1; lat = j + 1; end
    end
    total++; if (lat != 7) begin bad++; $display("FAIL basic_latency got=%0d exp=7", lat); end
    wait_results(base + 1, 40, ok);
    total++; if (!ok) begin bad++; $display("FAIL basic_result_timeout got=%0d exp=%0d results", got_q.size(), base + 1); end
    else begin
      total++; if (got_q[base] !== e) begin bad++; $display("FAIL basic_result got=%h exp=%h", got_q[base], e); end
    end
    repeat (2) align();
    total++; if ({n_start - s0, n_ack - a0} != {32'd1, 32'd1})
      begin bad++; $display("FAIL basic_pulses got start=%0d ack=%0d exp 1/1", n_start - s0, n_ack - a0); end
    total++; if (Busy !== 1'b0) begin bad++; $display("FAIL basic_busy got=%b exp=0", Busy); end
  endtask

  task automatic test_back_to_back();
    int s0 = n_start, a0 = n_ack, o0 = n_overlap, base = got_q.size();
    bit acc, ok;
    res_t e[3] = '{ {4'd5, 4'd8, 4'd0, 4'd5, 1'b0},
                    {4'd11, 4'd3, 4'd3, 4'd2, 1'b0},
                    {4'd15, 4'd1, 4'd15, 4'd0, 1'b0} };
    Res_Ready = 1'b1;
    for (int i = 0; i < 3; i++) push(e[i].x, e[i].y, acc);
    wait_results(base + 3, 120, ok);
    total++; if (!ok) begin bad++; $display("FAIL b2b_timeout got=%0d exp=%0d results", got_q.size(), base + 3); end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (base + i >= got_q.size()) begin bad++; $display("FAIL b2b_missing idx=%0d", i); end
      else if (got_q[base + i] !== e[i]) begin bad++; $display("FAIL b2b_result%0d got=%h exp=%h", i, got_q[base + i], e[i]); end
    end
    repeat (2) align();
    total++; if ({n_start - s0, n_ack - a0} != {32'd3, 32'd3})
      begin bad++; $display("FAIL b2b_pulses got start=%0d ack=%0d exp 3/3", n_start - s0, n_ack - a0); end
    total++; if (n_overlap != o0) begin bad++; $display("FAIL b2b_overlap got=%0d exp=%0d", n_overlap, o0); end
  endtask

  task automatic test_divzero();
    int s0 = n_start, base = got_q.size(), lat = 0;
    bit acc, ok, found = 0;
    res_t e = {4'd9, 4'd0, 4'd15, 4'd9, 1'b1};
    Res_Ready = 1'b1;
    push(4'd9, 4'd0, acc);
    for (int j = 0; j < 50 && !found; j++) begin
      @(negedge Clk);
      if (Res_Valid === 1'b1) begin found = 1; lat = j + 1; end
    end
    total++; if (lat != 2) begin bad++; $display("FAIL dz_latency got=%0d exp=2", lat); end
    wait_results(base + 1, 20, ok);
    total++; if (!ok || got_q[base] !== e)
      begin bad++; $display("FAIL dz_result got=%h exp=%h", ok ? got_q[base] : res_t'(0), e); end
    repeat (3) align();
    total++; if (n_start != s0) begin bad++; $display("FAIL dz_no_start got=%0d exp=0 starts", n_start - s0); end
  endtask

  task automatic test_backpressure();
    int s0 = n_start, a0 = n_ack, base = got_q.size(), unstable = 0;
    bit acc, ok, found = 0;
    bit exp_acc[6] = '{1, 1, 1, 1, 0, 0};
    logic [3:0] px[6] = '{4'd8, 4'd13, 4'd6, 4'd12, 4'd1, 4'd2};
    logic [3:0] py[6] = '{4'd3, 4'd4, 4'd0, 4'd5, 4'd1, 4'd2};
    res_t e[5] = '{ {4'd7, 4'd2, 4'd3, 4'd1, 1'b0},
                    {4'd8, 4'd3, 4'd2, 4'd2, 1'b0},
                    {4'd13, 4'd4, 4'd3, 4'd1, 1'b0},
                    {4'd6, 4'd0, 4'd15, 4'd6, 1'b1},
                    {4'd12, 4'd5, 4'd2, 4'd2, 1'b0} };
    Res_Ready = 1'b0;
    push(4'd7, 4'd2, acc);
    for (int j = 0; j < 50 && !found; j++) begin
      @(negedge Clk);
      if (Res_Valid === 1'b1) found = 1;
    end
    total++; if (!found) begin bad++; $display("FAIL bp_first_valid got=0 exp=1"); end
    align();
    for (int i = 0; i < 6; i++) begin
      if (i == 4) begin
        total++; if (Op_Ready !== 1'b0) begin bad++; $display("FAIL bp_op_ready_full got=%b exp=0", Op_Ready); end
      end
      push(px[i], py[i], acc);
      total++; if (acc != exp_acc[i]) begin bad++; $display("FAIL bp_accept%0d got=%b exp=%b", i, acc, exp_acc[i]); end
    end
    for (int j = 0; j < 8; j++) begin
      @(negedge Clk);
      if (Res_Valid !== 1'b1 || {Res_X, Res_Y, Res_Quotient, Res_Remainder, Res_DivZero} !== e[0]) unstable++;
    end
    total++; if (unstable != 0) begin bad++; $display("FAIL bp_hold_stable got=%0d changes exp=0", unstable); end
    align();
    Res_Ready = 1'b1;
    wait_results(base + 5, 300, ok);
    total++; if (!ok) begin bad++; $display("FAIL bp_drain_timeout got=%0d exp=%0d results", got_q.size(), base + 5); end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (base + i >= got_q.size()) begin bad++; $display("FAIL bp_missing idx=%0d", i); end
      else if (got_q[base + i] !== e[i]) begin bad++; $display("FAIL bp_result%0d got=%h exp=%h", i, got_q[base + i], e[i]); end
    end
    repeat (3) align();
    total++; if ({Op_Ready, Busy, got_q.size() == base + 5} !== 3'b101)
      begin bad++; $display("FAIL bp_final got ready/busy/count=%b exp=101", {Op_Ready, Busy, got_q.size() == base + 5}); end
    total++; if ({n_start - s0, n_ack - a0} != {32'd4, 32'd4})
      begin bad++; $display("FAIL bp_pulses got start=%0d ack=%0d exp 4/4", n_start - s0, n_ack - a0); end
  endtask

  task automatic test_reset_mid_op();
    int base = got_q.size();
    bit acc, ok;
    res_t e = {4'd14, 4'd3, 4'd4, 4'd2, 1'b0};
    Res_Ready = 1'b1;
    div_delay = 20;
    push(4'd14, 4'd3, acc);
    push(4'd2, 4'd1, acc);
    repeat (4) align();
    total++; if ({Busy, stub_busy} !== 2'b11) begin bad++; $display("FAIL rst_mid_pre got busy/stub=%b exp=11", {Busy, stub_busy}); end
    Reset = 1'b0;
    #1;
    total++; if ({Op_Ready, Busy, Res_Valid, Div_Start, Div_Ack} !== 5'b10000)
      begin bad++; $display("FAIL rst_mid_ctrl got=%b exp=10000", {Op_Ready, Busy, Res_Valid, Div_Start, Div_Ack}); end
    total++; if ({Div_Xin, Div_Yin, Res_X, Res_Quotient} !== 16'h0)
      begin bad++; $display("FAIL rst_mid_data got=%h exp=0", {Div_Xin, Div_Yin, Res_X, Res_Quotient}); end
    align();
    Reset = 1'b1;
    div_delay = 3;
    repeat (30) align();
    total++; if (got_q.size() != base || Busy !== 1'b0)
      begin bad++; $display("FAIL rst_mid_abandon got results=%0d busy=%b exp 0/0", got_q.size() - base, Busy); end
    push(4'd14, 4'd3, acc);
    wait_results(base + 1, 40, ok);
    total++; if (!ok || got_q[base] !== e)
      begin bad++; $display("FAIL rst_mid_retry got=%h exp=%h", ok ? got_q[base] : res_t'(0), e); end
  endtask

`ifdef DIVHOST_TIMEOUT_EN
  task automatic test_timeout();
    int a0 = n_ack, base = got_q.size(), k = 0;
    bit acc, ok, found = 0;
    res_t e0 = {4'd10, 4'd2, 4'd0, 4'd0, 1'b0};
    res_t e1 = {4'd10, 4'd2, 4'd5, 4'd0, 1'b0};
    Res_Ready = 1'b1;
    stub_hang = 1'b1;
    push(4'd10, 4'd2, acc);
    for (int j = 0; j < 10 && !found; j++) begin
      @(negedge Clk);
      if (Div_Start === 1'b1) found = 1;
    end
    found = 0;
    while (!found && k < 100) begin
      @(negedge Clk); k++;
      if (Div_Ack === 1'b1) found = 1;
    end
    total++; if (k != 33) begin bad++; $display("FAIL tmo_wait_cycles got=%0d exp=33", k); end
    wait_results(base + 1, 20, ok);
    total++; if (!ok || got_q[base] !== e0)
      begin bad++; $display("FAIL tmo_result got=%h exp=%h", ok ? got_q[base] : res_t'(0), e0); end
    total++; if (Err_Timeout !== 1'b1) begin bad++; $display("FAIL tmo_flag got=%b exp=1", Err_Timeout); end
    stub_hang = 1'b0;
    push(4'd10, 4'd2, acc);
    wait_results(base + 2, 40, ok);
    total++; if (!ok || got_q[base + 1] !== e1)
      begin bad++; $display("FAIL tmo_after_good got=%h exp=%h", ok ? got_q[base + 1] : res_t'(0), e1); end
    total++; if (Err_Timeout !== 1'b1 || n_ack - a0 != 2)
      begin bad++; $display("FAIL tmo_sticky got flag=%b acks=%0d exp 1/2", Err_Timeout, n_ack - a0); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_divzero();
    test_backpressure();
    test_reset_mid_op();
`ifdef DIVHOST_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/divider_host_ctrl.md
Name: divider_host_ctrl

Overview:
Host-side sequencer that sits directly upstream and downstream of divider_timing. Buffers 4-bit operand pairs in a small FIFO and drives the divider's Xin/Yin/Start/Ack/Done handshake one operation at a time. Returns each Quotient/Remainder, tagged with its operands, on a valid/ready result port. Divide-by-zero is resolved locally and never reaches the divider.

Parameters:
FIFO_DEPTH, 4, operand FIFO entries (power of 2, 2..16)
DIV_TIMEOUT, 32, max clocks in WAIT_DONE before abort (only with DIVHOST_TIMEOUT_EN)

Ports:
Clk  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-low (0 = reset)
Op_Valid  in  1  operand push request
Op_X  in  4  dividend
Op_Y  in  4  divisor
Op_Ready  out  1  FIFO not full
Div_Xin  out  4  to divider Xin, registered
Div_Yin  out  4  to divider Yin, registered
Div_Start  out  1  to divider Start
Div_Ack  out  1  to divider Ack
Div_Done  in  1  from divider Done
Div_Quotient  in  4  from divider
Div_Remainder  in  4  from divider
Res_Valid  out  1  result available
Res_Ready  in  1  result consumed
Res_X, Res_Y  out  4 each  operands of this result
Res_Quotient, Res_Remainder  out  4 each  result
Res_DivZero  out  1  result is divide-by-zero
Busy  out  1  FSM not in IDLE or FIFO non-empty

Behaviour:
- Reset (async, Reset=0): FIFO emptied, FSM=IDLE, every output 0 except Op_Ready=1. Reset mid-operation abandons the op with no result. The divider is reset from the same source (inverted), so no divider state is assumed to survive reset.
- FIFO push occurs on an edge where Op_Valid & Op_Ready. Op_Ready = (count != FIFO_DEPTH). Push while full is ignored. No bypass: a new entry is popped the edge after it is written at the earliest.
- FSM states: IDLE, START, WAIT_DONE, ACK, OUT.
- IDLE: if FIFO non-empty, pop the head and latch it into Div_Xin/Div_Yin and Res_X/Res_Y.
  - Y==0: Res_Quotient=4'hF, Res_Remainder=X, Res_DivZero=1, go to OUT.
  - Otherwise: Res_DivZero=0, go to START.
- START: Div_Start=1 for exactly one cycle, then go to WAIT_DONE. Div_Xin/Div_Yin are stable from the IDLE pop until the FSM leaves ACK.
- WAIT_DONE: Div_Start=0. On an edge with Div_Done=1, capture Div_Quotient/Div_Remainder into Res_Quotient/Res_Remainder and go to ACK.
- ACK: Div_Ack=1 for exactly one cycle, then go to OUT.
- OUT: Res_Valid=1. Res_* are held stable until an edge with Res_Ready=1, then Res_Valid drops and the FSM returns to IDLE.
  - Res_Ready may be high before Res_Valid; the result is then consumed on the first OUT edge.
- Minimum latency, push edge N to Res_Valid high:
  - Normal op: N+4+D, where D = clocks from Start edge to Done edge.
  - Y==0 op: N+2.
- FIFO push and pop on the same edge are both performed; count is unchanged.
- One result is in flight at a time. The FIFO keeps accepting pushes while the FSM is busy.
- Division is 4-bit unsigned throughout; no widening.

Optional Feature:
Macro DIVHOST_TIMEOUT_EN.
- Defined:
  - A 6-bit counter clears on entry to WAIT_DONE and increments each WAIT_DONE cycle.
  - When the counter reaches DIV_TIMEOUT with Div_Done still 0: go to ACK (Ack pulse resets the divider's handshake), then to OUT with Res_Quotient=0, Res_Remainder=0, Res_DivZero=0.
  - Extra output Err_Timeout (1 bit) sets on this event and stays sticky until reset.
- Undefined: no counter and no Err_Timeout port; WAIT_DONE waits indefinitely.

Test Plan:
- Push (15,2) with Res_Ready=1 -> one Div_Start pulse, then one Div_Ack pulse; result Q=7, R=1, DivZero=0.
- Back-to-back push of (5,8),(11,3),(15,1) -> results returned in order: Q0/R5, Q3/R2, Q15/R0; exactly one Start and one Ack per op; never two ops on the divider at once.
- Push (9,0) -> Div_Start never asserts; Res_Valid at N+2 with Q=15, R=9, DivZero=1.
- Hold Res_Ready=0 and push 6 ops -> Op_Ready low after FIFO fills; 5th and 6th pushes dropped while Op_Ready is low; Res_* stable while Res_Valid=1; releasing Res_Ready drains all accepted ops in order.
- Assert Reset=0 during WAIT_DONE of (14,3) -> outputs clear immediately, FIFO empty, Op_Ready=1; a subsequent (14,3) returns Q=4, R=2.
- With DIVHOST_TIMEOUT_EN: stub divider holds Div_Done=0 -> after 32 WAIT_DONE cycles one Ack pulse, result Q=0/R=0, Err_Timeout=1 and still 1 after later good ops.
